// File: rtl/bnn_layer_sequencer.sv
// Sequences one BNN layer: latch an input vector, then per tile fetch weights,
// hold them on the combinational datapath, capture the result and stream it out.
module bnn_layer_sequencer #(
  parameter int INPUT_DIM  = 10,
  parameter int OUTPUT_DIM = 10,
  parameter int TILE_W     = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [TILE_W-1:0]                num_tiles,
  output logic                             busy,
  output logic                             done,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [INPUT_DIM*8-1:0]           in_vec,
  output logic                             wmem_rd_en,
  output logic [TILE_W-1:0]                wmem_addr,
  input  logic [OUTPUT_DIM*INPUT_DIM*8-1:0] wmem_rd_data,
  output logic [INPUT_DIM*8-1:0]           dp_value_in,
  output logic [OUTPUT_DIM*INPUT_DIM*8-1:0] dp_weight,
  input  logic [OUTPUT_DIM*8-1:0]          dp_value_out,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OUTPUT_DIM*8-1:0]          out_data,
  output logic [TILE_W-1:0]                out_tile
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_IN,
    S_FETCH,
    S_WAIT,
    S_COMPUTE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [TILE_W-1:0] num_tiles_q;
  logic [TILE_W-1:0] tile_q;
  logic              last_tile;

  // num_tiles_q is never zero outside IDLE/DONE, so the subtraction cannot wrap in EMIT.
  assign last_tile = (tile_q == num_tiles_q - TILE_W'(1));
  assign wmem_addr = tile_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    in_ready   = 1'b0;
    wmem_rd_en = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = (num_tiles == '0) ? S_DONE : S_LOAD_IN;
      end
      S_LOAD_IN: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        wmem_rd_en = 1'b1;
        state_nxt  = S_WAIT;
      end
      S_WAIT:    state_nxt = S_COMPUTE;
      S_COMPUTE: state_nxt = S_EMIT;
      S_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = last_tile ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the wide data registers are reset too, so a dropped layer never
  // leaves stale vectors or results visible on the outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      num_tiles_q <= '0;
      tile_q      <= '0;
      dp_value_in <= '0;
      dp_weight   <= '0;
      out_data    <= '0;
      out_tile    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            num_tiles_q <= num_tiles;
            tile_q      <= '0;
          end
        end
        S_LOAD_IN: begin
          if (in_valid) dp_value_in <= in_vec;
        end
        // Read data arrives one cycle after the FETCH strobe.
        S_WAIT: dp_weight <= wmem_rd_data;
        S_COMPUTE: begin
          out_data <= dp_value_out;
          out_tile <= tile_q;
        end
        S_EMIT: begin
          if (out_ready && !last_tile) tile_q <= tile_q + TILE_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Randomized bench for bnn_layer_sequencer: weight memory and datapath models,
// a per-layer expected-result table and one negedge compare process.
module tb_bnn_layer_sequencer;
  localparam int INPUT_DIM  = 10;
  localparam int OUTPUT_DIM = 10;
  localparam int TILE_W     = 4;
  localparam int VEC_W      = INPUT_DIM * 8;
  localparam int OUT_W      = OUTPUT_DIM * 8;
  localparam int WGT_W      = OUTPUT_DIM * INPUT_DIM * 8;

  logic              clock = 1'b0;
  logic              reset, start, in_valid, out_ready;
  logic [TILE_W-1:0] num_tiles;
  logic              busy, done, in_ready, wmem_rd_en, out_valid;
  logic [VEC_W-1:0]  in_vec, dp_value_in;
  logic [TILE_W-1:0] wmem_addr, out_tile;
  logic [WGT_W-1:0]  wmem_rd_data, dp_weight;
  logic [OUT_W-1:0]  dp_value_out, out_data;

  bnn_layer_sequencer #(.INPUT_DIM(INPUT_DIM), .OUTPUT_DIM(OUTPUT_DIM), .TILE_W(TILE_W)) dut (
    .clock(clock), .reset(reset), .start(start), .num_tiles(num_tiles),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .wmem_rd_en(wmem_rd_en), .wmem_addr(wmem_addr), .wmem_rd_data(wmem_rd_data),
    .dp_value_in(dp_value_in), .dp_weight(dp_weight), .dp_value_out(dp_value_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tile(out_tile)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Weight SRAM with one-cycle read latency.
  logic [WGT_W-1:0] wmem [16];
  always @(posedge clock) if (wmem_rd_en) wmem_rd_data <= wmem[wmem_addr];

  // Datapath: each output is a signed +/-1 weighted sum of the inputs, modulo 256.
  function automatic logic [OUT_W-1:0] dp_fn(input logic [VEC_W-1:0] v, input logic [WGT_W-1:0] w);
    logic [OUT_W-1:0] r;
    int acc;
    r = '0;
    for (int o = 0; o < OUTPUT_DIM; o++) begin
      acc = 0;
      for (int i = 0; i < INPUT_DIM; i++) begin
        int x;
        x = int'(v[8*i +: 8]);
        acc += w[8*(o*INPUT_DIM+i)] ? x : -x;
      end
      r[8*o +: 8] = acc[7:0];
    end
    return r;
  endfunction

  always_comb dp_value_out = dp_fn(dp_value_in, dp_weight);

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected results for the current layer and monitor bookkeeping.
  logic [OUT_W-1:0]  exp_out [16];
  int                fetch_count, emit_count, done_count, stall_seen;
  int                last_fetch_cyc, last_ev_cyc, done_cyc, start_cyc;
  bit                track, input_pending, prev_valid, hold_pending;
  logic [OUT_W-1:0]  held_data;
  logic [TILE_W-1:0] held_tile;
  int                ready_mode, stall_left;

  always @(negedge clock) begin
    if (reset || !track) begin
      prev_valid   = 1'b0;
      hold_pending = 1'b0;
    end else begin
      if (in_ready) begin
        check("in_ready_when_expected", input_pending, 1);
        if (in_valid) begin
          input_pending = 1'b0;
          last_ev_cyc   = cyc;
        end
      end
      if (wmem_rd_en) begin
        check("wmem_addr", wmem_addr, fetch_count);
        check("fetch_after_handshake", cyc - last_ev_cyc, 1);
        fetch_count++;
        last_fetch_cyc = cyc;
      end
      if (out_valid) begin
        if (!prev_valid) check("emit_latency", cyc - last_fetch_cyc, 3);
        if (hold_pending) begin
          check("hold_data", out_data, held_data);
          check("hold_tile", out_tile, held_tile);
        end
        if (out_ready) begin
          check("out_tile", out_tile, emit_count);
          check("out_data", out_data, (emit_count < 16) ? exp_out[emit_count] : '0);
          emit_count++;
          last_ev_cyc  = cyc;
          hold_pending = 1'b0;
        end else begin
          hold_pending = 1'b1;
          held_data    = out_data;
          held_tile    = out_tile;
          stall_seen++;
        end
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
      prev_valid = out_valid;
    end
  end

  // Downstream ready: always, random, a 7-cycle stall on tile 1.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        1: out_ready = ($urandom_range(0, 2) != 0);
        2: begin
          if (out_valid && out_tile == 1 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else out_ready = 1'b1;
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic run_layer(input int n, input int mode, input bit poke, input int abort_tile,
                           input bit fixed);
    logic [VEC_W-1:0] v;
    bit poked, aborted;
    poked   = 1'b0;
    aborted = 1'b0;
    for (int i = 0; i < INPUT_DIM; i++) v[8*i +: 8] = fixed ? 8'(i + 1) : 8'($urandom);
    for (int t = 0; t < 16; t++)
      for (int k = 0; k < WGT_W / 32; k++) wmem[t][32*k +: 32] = $urandom;
    if (fixed) begin
      wmem[0] = '1;
      wmem[1] = '0;
    end
    for (int t = 0; t < 16; t++) exp_out[t] = dp_fn(v, wmem[t]);
    if (fixed) begin
      // 1+2+..+10 = 55 = 0x37; its negation modulo 256 is 0xC9.
      check("model_all_plus", exp_out[0], {OUTPUT_DIM{8'h37}});
      check("model_all_minus", exp_out[1], {OUTPUT_DIM{8'hC9}});
    end

    ready_mode  = mode;
    stall_left  = 7;
    fetch_count = 0;
    emit_count  = 0;
    done_count  = 0;
    stall_seen  = 0;
    track       = 1'b1;

    @(posedge clock);
    #1;
    start     = 1'b1;
    num_tiles = TILE_W'(n);
    in_vec    = v;
    in_valid  = 1'($urandom_range(0, 1));
    start_cyc = cyc;
    @(posedge clock);
    #1;
    start         = 1'b0;
    num_tiles     = TILE_W'($urandom);
    input_pending = (n != 0);

    for (int c = 0; c < 3000 && done_count == 0; c++) begin
      if (in_valid && !input_pending) begin
        in_valid = 1'b0;
        in_vec   = {VEC_W/32{$urandom}};
      end else if (!in_valid && input_pending && $urandom_range(0, 2) == 0) in_valid = 1'b1;
      if (poke && !poked && fetch_count == 2 && cyc == last_fetch_cyc + 2) begin
        start     = 1'b1;
        num_tiles = TILE_W'(1);
        poked     = 1'b1;
      end else start = 1'b0;
      if (abort_tile >= 0 && out_valid && out_tile == TILE_W'(abort_tile)) begin
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset   = 1'b0;
        aborted = 1'b1;
        break;
      end
      @(posedge clock);
      #1;
    end
    start    = 1'b0;
    in_valid = 1'b0;

    if (abort_tile >= 0) begin
      track = 1'b0;
      check("abort_reached", aborted, 1);
      @(negedge clock);
      check("abort_out_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_out_data", out_data, 0);
      check("abort_in_ready", in_ready, 0);
      for (int c = 0; c < 3; c++) begin
        @(negedge clock);
        check("abort_no_done", done, 0);
      end
      return;
    end

    repeat (3) @(posedge clock);
    #1;
    track = 1'b0;
    check("done_seen_once", done_count, 1);
    check("tiles_emitted", emit_count, n);
    check("tiles_fetched", fetch_count, n);
    check("busy_after_done", busy, 0);
    if (n == 0) check("zero_tile_done_latency", done_cyc - start_cyc, 1);
    else begin
      check("dp_value_in_held", dp_value_in, v);
      check("dp_weight_last", dp_weight, wmem[n-1]);
    end
    if (mode == 2) check("stall_cycles", stall_seen, 7);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    num_tiles  = '0;
    in_valid   = 1'b0;
    in_vec     = '0;
    ready_mode = 0;
    track      = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_wmem_rd_en", wmem_rd_en, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tile", out_tile, 0);
    check("rst_dp_value_in", dp_value_in, 0);
    check("rst_dp_weight", dp_weight[127:0], 0);

    run_layer(3, 0, 1'b0, -1, 1'b1);   // directed vector 0x01..0x0A
    run_layer(0, 0, 1'b0, -1, 1'b0);   // empty layer
    run_layer(4, 2, 1'b0, -1, 1'b0);   // 7-cycle stall on tile 1
    run_layer(3, 0, 1'b1, -1, 1'b0);   // start poked during COMPUTE of tile 1
    run_layer(15, 0, 1'b0, -1, 1'b0);  // maximum tile count
    run_layer(5, 0, 1'b0, 2, 1'b0);    // reset in EMIT of tile 2
    for (int l = 0; l < 6; l++) run_layer(int'($urandom_range(1, 15)), 1, 1'b0, -1, 1'b0);
    run_layer(2, 1, 1'b0, -1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
